// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M/RV64M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up and a registered result.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [XLEN-1:0]   ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONE_W    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ONES_W   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_W    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_2W   = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v);
        return ~v + ONE_2W;
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     op_b_q, op_b_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed_s, b_signed_s;
    logic                in_sign_a_s, in_sign_b_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s;
    logic                div_zero_s, div_ovf_s;
    logic [XLEN:0]       mul_add_s;
    logic [2*XLEN-1:0]   mul_next_s;
    logic [XLEN:0]       rem_sh_s, div_diff_s;
    logic                q_bit_s;
    logic [2*XLEN-1:0]   div_next_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s, rem_s, fix_result_s;

    // Operand signedness, magnitudes and divide special cases at the accept point
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (i_funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'd2: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        in_sign_a_s = a_signed_s & i_op_a[XLEN-1];
        in_sign_b_s = b_signed_s & i_op_b[XLEN-1];
        mag_a_s     = in_sign_a_s ? neg_w(i_op_a) : i_op_a;
        mag_b_s     = in_sign_b_s ? neg_w(i_op_b) : i_op_b;
        div_zero_s  = i_funct3[2] && (i_op_b == ZERO_W);
        div_ovf_s   = i_funct3[2] && !i_funct3[0] && (i_op_a == MIN_W) && (i_op_b == ONES_W);
    end

    // One iteration step: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_add_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_b_q} : {(XLEN+1){1'b0}});
        mul_next_s = {mul_add_s, acc_q[XLEN-1:1]};
        rem_sh_s   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff_s = rem_sh_s - {1'b0, op_b_q};
        q_bit_s    = ~div_diff_s[XLEN];
        div_next_s = {(q_bit_s ? div_diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0]),
                      acc_q[XLEN-2:0], q_bit_s};
    end

    // Sign fix-up and output selection applied in FIX
    always_comb begin
        prod_s = (sign_a_q ^ sign_b_q) ? neg_2w(acc_q) : acc_q;
        quo_s  = (sign_a_q ^ sign_b_q) ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
        rem_s  = sign_a_q ? neg_w(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
        case (funct3_q)
            3'd0:             fix_result_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_result_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_result_s = quo_s;
            3'd6, 3'd7:       fix_result_s = rem_s;
            default:          fix_result_s = ZERO_W;
        endcase
    end

    // Next-state and register update logic; flush overrides every state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        acc_d    = acc_q;
        op_b_d   = op_b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        result_d = result_q;
        if (i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_in_valid) begin
                        funct3_d = i_funct3;
                        cnt_d    = CNT_LOAD;
                        if (div_zero_s) begin
                            // Special results are preloaded raw: {remainder, quotient}
                            acc_d    = {i_op_a, ONES_W};
                            op_b_d   = i_op_b;
                            sign_a_d = 1'b0;
                            sign_b_d = 1'b0;
                            state_d  = S_FIX;
                        end else if (div_ovf_s) begin
                            acc_d    = {ZERO_W, MIN_W};
                            op_b_d   = i_op_b;
                            sign_a_d = 1'b0;
                            sign_b_d = 1'b0;
                            state_d  = S_FIX;
                        end else begin
                            acc_d    = {ZERO_W, mag_a_s};
                            op_b_d   = mag_b_s;
                            sign_a_d = in_sign_a_s;
                            sign_b_d = in_sign_b_s;
                            state_d  = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_d = funct3_q[2] ? div_next_s : mul_next_s;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    result_d = fix_result_s;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            funct3_q <= 3'd0;
            acc_q    <= {(2*XLEN){1'b0}};
            op_b_q   <= ZERO_W;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result_q <= ZERO_W;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            acc_q    <= acc_d;
            op_b_q   <= op_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            result_q <= result_d;
        end
    end

    assign o_in_ready  = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_out_valid = (state_q == S_DONE);
    assign o_result    = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random operations checked
// against a plain-arithmetic RV32M reference model, plus backpressure, flush and reset.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_V  = 32'h8000_0000;
    localparam logic [31:0] ONES_V = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_funct3    (funct3),
        .i_op_a      (op_a),
        .i_op_b      (op_b),
        .i_flush     (flush),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_result    (result),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, za, zb, p;
        logic signed [31:0] as_v, bs_v;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'd0, a};
        zb = {32'd0, b};
        as_v = a;
        bs_v = b;
        p = 64'sd0;
        r = 32'd0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * zb; r = p[63:32]; end
            3'd3: begin p = za * zb; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = ONES_V;
                else if (a == MIN_V && b == ONES_V) r = MIN_V;
                else r = 32'(as_v / bs_v);
            end
            3'd5: r = (b == 32'd0) ? ONES_V : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == MIN_V && b == ONES_V) r = 32'd0;
                else r = 32'(as_v % bs_v);
            end
            3'd7: r = (b == 32'd0) ? a : a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Edges from and including the accept edge until o_out_valid is seen high
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && (b == 32'd0 || (!f3[0] && a == MIN_V && b == ONES_V))) return 2;
        return XLEN + 2;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return MIN_V;
            2: return ONES_V;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp_r;
        int lat;
        exp_r = ref_model(f3, a, b);
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        @(negedge clk);
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(ref_latency(f3, a, b)));
        check({tag, "_result"}, result, exp_r);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_result"}, result, exp_r);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        funct3    = 3'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mulh_m1", 3'd1, ONES_V, ONES_V, 0);
        run_op("mulhu_ff", 3'd3, ONES_V, ONES_V, 0);
        run_op("mulhsu", 3'd2, ONES_V, 32'd2, 0);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 0);
        run_op("divu_by0", 3'd5, 32'h1234, 32'd0, 0);
        run_op("rem_by0", 3'd6, 32'h1234, 32'd0, 0);
        run_op("div_ovf", 3'd4, MIN_V, ONES_V, 0);
        run_op("rem_ovf", 3'd6, MIN_V, ONES_V, 0);

        run_op("bp_mul", 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        run_op("bp_next", 3'd4, 32'hFFFF_FC18, 32'd10, 0);

        // Flush in CALC: return to IDLE, no result ever delivered
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid = 1;
        end
        check("flush_no_valid", 32'(seen_valid), 32'd0);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 32'd50; op_b = 32'd5;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", {31'd0, busy}, 32'd0);
        run_op("after_flush", 3'd5, 32'd50, 32'd5, 0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1; funct3 = 3'd1; op_a = 32'h7FFF_FFFF; op_b = 32'h7FFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rf;
            logic [31:0] ra, rb;
            rf = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
